// File: rtl/wb_init_pkg.sv
// Shared types and defaults for the Wishbone B4 classic initiator bridge.
package wb_init_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WB_AW     = 32;
  localparam int WB_DW     = 32;
  localparam int TIMEOUT_W = 8;

endpackage

// File: rtl/wb_init_watchdog.sv
// Bus-cycle watchdog: counts BUS cycles and flags the TIMEOUT-th one so the
// initiator can abort a cycle the responder never terminates.
module wb_init_watchdog
  import wb_init_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of BUS cycles already completed, so this fires in
  // the TIMEOUT-th cycle and cyc stays high for exactly TIMEOUT cycles.
  assign expired = run && (r_cnt == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_initiator_bridge.sv
// Valid/ready request/response front end to single Wishbone B4 classic cycles.
// Optional bus watchdog enabled by defining WB_INIT_TIMEOUT_EN.
module wb_initiator_bridge
  import wb_init_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  // Handshake rule on both front-end channels: a transfer happens on a rising
  // edge where valid and ready are both high; valid holds its payload until then.
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_adr,
  input  logic [DW-1:0]   req_dat,
  input  logic [DW/8-1:0] req_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  output state_t          dbg_state
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_we;
  logic [AW-1:0]     r_adr;
  logic [DW-1:0]     r_dat;
  logic [DW/8-1:0]   r_sel;
  logic [DW-1:0]     r_rsp_dat;
  logic              r_rsp_err;
  logic              w_accept;
  logic              w_term;
  logic              w_expired;

`ifdef WB_INIT_TIMEOUT_EN
  wb_init_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .clr    (w_accept),
    .run    (r_state == BUS),
    .expired(w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_expired        = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_term   = (r_state == BUS) && (wbm_ack_i || wbm_err_i || w_expired);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next_state = BUS;
      BUS:     if (w_term) w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we  <= req_we;
        r_adr <= req_adr;
        r_dat <= req_dat;
        r_sel <= req_sel;
      end
      // Only a clean ack is a success; err (even alongside ack) and a
      // watchdog abort both report an error with zero data.
      if (w_term) begin
        r_rsp_err <= wbm_err_i || !wbm_ack_i;
        r_rsp_dat <= (wbm_ack_i && !wbm_err_i && !r_we) ? wbm_dat_i : '0;
      end
    end
  end

  // Every output decodes flops only, so reset drops cyc/stb asynchronously.
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign wbm_cyc_o = (r_state == BUS);
  assign wbm_stb_o = (r_state == BUS);
  assign wbm_we_o  = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = r_sel;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_wb_initiator_bridge.sv
// Self-checking bench for wb_initiator_bridge: directed scenarios plus
// randomized transactions against a response-level reference model.
module tb_wb_initiator_bridge;
  import wb_init_pkg::*;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_adr = '0;
  logic [DW-1:0] req_dat = '0;
  logic [SW-1:0] req_sel = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [SW-1:0] wbm_sel_o;
  logic [DW-1:0] wbm_dat_i = '0;
  logic          wbm_ack_i = 1'b0;
  logic          wbm_err_i = 1'b0;
  state_t        dbg_state;

  wb_initiator_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_dat  (req_dat),
    .req_sel  (req_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_time_limit got running exp finished");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  int              n_checks = 0;
  int              n_errors = 0;
  logic [DW:0]     exp_q[$];
  logic [DW:0]     exp_rsp;

  int              obs_cycles;
  bit              obs_hold_ok;
  bit              obs_dropped;
  bit              obs_hung;
  bit              obs_rsp_seen;
  bit              obs_bp_ok;
  bit              obs_done_ok;
  logic [DW-1:0]   obs_dat;
  logic            obs_err;

  // Response the consumer must see: {err, data}. No ack and no err means the
  // cycle was aborted by the watchdog.
  function automatic logic [DW:0] model_rsp(bit we, bit ack, bit err, logic [DW-1:0] rdata);
    if (err || !ack) return {1'b1, {DW{1'b0}}};
    if (we) return '0;
    return {1'b0, rdata};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the bridge idle. Plays one request, acts as the
  // responder (ack/err after 'waits' wait states; waits<0 never answers), then
  // consumes the response after 'bp' cycles of backpressure. Records what it saw.
  task automatic run_txn(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, input int waits, input bit ack, input bit err,
                         input logic [DW-1:0] rdata, input int bp, input bit early_ready);
    obs_cycles   = 0;
    obs_hold_ok  = 1'b1;
    obs_dropped  = 1'b0;
    obs_hung     = 1'b0;
    obs_rsp_seen = 1'b0;
    obs_bp_ok    = 1'b1;
    obs_done_ok  = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    req_sel   = sel;
    rsp_ready = early_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_adr   = $urandom;
    req_dat   = $urandom;
    for (int i = 0; i < 1000; i++) begin
      if (!(wbm_cyc_o && wbm_stb_o)) begin
        obs_dropped = 1'b1;
        break;
      end
      obs_cycles++;
      if (wbm_we_o !== we || wbm_adr_o !== adr || wbm_dat_o !== dat || wbm_sel_o !== sel ||
          req_ready !== 1'b0 || rsp_valid !== 1'b0)
        obs_hold_ok = 1'b0;
      if (obs_cycles == waits + 1) begin
        wbm_ack_i = ack;
        wbm_err_i = err;
        wbm_dat_i = rdata;
      end
      @(posedge clk);
      @(negedge clk);
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = $urandom;
      if (obs_cycles == waits + 1) break;
    end
    if (!obs_dropped && waits < 0) begin
      obs_hung = 1'b1;
      return;
    end
    obs_rsp_seen = rsp_valid;
    obs_dat      = rsp_dat;
    obs_err      = rsp_err;
    if (wbm_cyc_o !== 1'b0) obs_bp_ok = 1'b0;
    if (!early_ready) begin
      repeat (bp) begin
        @(posedge clk);
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_dat !== obs_dat || rsp_err !== obs_err ||
            req_ready !== 1'b0 || wbm_cyc_o !== 1'b0)
          obs_bp_ok = 1'b0;
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready   = 1'b0;
    obs_done_ok = (rsp_valid === 1'b0 && req_ready === 1'b1 && wbm_cyc_o === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({req_ready, wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_ctrl got %b exp 10000", {req_ready, wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err});
    end
    n_checks++;
    if (rsp_dat !== '0 || wbm_adr_o !== '0 || wbm_dat_o !== '0 || wbm_sel_o !== '0 || wbm_we_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_data got rsp_dat=%h adr=%h exp zeros", rsp_dat, wbm_adr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== IDLE || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release got state=%0d ready=%b exp state=0 ready=1", dbg_state, req_ready);
    end
  endtask

  task automatic test_write_zero_wait;
    exp_q.push_back(model_rsp(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D));
    run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, 1'b0, 32'h0BAD_F00D, 0, 1'b0);
    exp_rsp = exp_q.pop_front();
    n_checks++;
    if (obs_cycles !== 1 || !obs_hold_ok) begin
      n_errors++;
      $display("FAIL write_stb_cycles got %0d hold_ok=%0d exp 1 hold_ok=1", obs_cycles, obs_hold_ok);
    end
    n_checks++;
    if (!obs_rsp_seen || {obs_err, obs_dat} !== exp_rsp) begin
      n_errors++;
      $display("FAIL write_rsp got valid=%0d %h exp valid=1 %h", obs_rsp_seen, {obs_err, obs_dat}, exp_rsp);
    end
    n_checks++;
    if (!obs_done_ok) begin
      n_errors++;
      $display("FAIL write_done got not_idle exp idle");
    end
  endtask

  task automatic test_read_wait3;
    exp_q.push_back(model_rsp(1'b0, 1'b1, 1'b0, 32'h1234_5678));
    run_txn(1'b0, 32'h0000_0100, 32'h5555_AAAA, 4'h3, 3, 1'b1, 1'b0, 32'h1234_5678, 0, 1'b0);
    exp_rsp = exp_q.pop_front();
    n_checks++;
    if (obs_cycles !== 4 || !obs_hold_ok) begin
      n_errors++;
      $display("FAIL read_wait_cycles got %0d hold_ok=%0d exp 4 hold_ok=1", obs_cycles, obs_hold_ok);
    end
    n_checks++;
    if (!obs_rsp_seen || {obs_err, obs_dat} !== exp_rsp) begin
      n_errors++;
      $display("FAIL read_rsp got %h exp %h", {obs_err, obs_dat}, exp_rsp);
    end
  endtask

  task automatic test_err_with_ack;
    exp_q.push_back(model_rsp(1'b0, 1'b1, 1'b1, 32'hCAFE_0001));
    run_txn(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, 1'b1, 1'b1, 32'hCAFE_0001, 0, 1'b0);
    exp_rsp = exp_q.pop_front();
    n_checks++;
    if (!obs_rsp_seen || {obs_err, obs_dat} !== exp_rsp) begin
      n_errors++;
      $display("FAIL err_ack_rsp got %h exp %h", {obs_err, obs_dat}, exp_rsp);
    end
  endtask

  task automatic test_backpressure;
    exp_q.push_back(model_rsp(1'b0, 1'b1, 1'b0, 32'hA5A5_0F0F));
    run_txn(1'b0, 32'h0000_0300, 32'h0, 4'hC, 1, 1'b1, 1'b0, 32'hA5A5_0F0F, 5, 1'b0);
    exp_rsp = exp_q.pop_front();
    n_checks++;
    if (!obs_bp_ok) begin
      n_errors++;
      $display("FAIL backpressure_hold got unstable exp stable");
    end
    n_checks++;
    if ({obs_err, obs_dat} !== exp_rsp || !obs_done_ok) begin
      n_errors++;
      $display("FAIL backpressure_rsp got %h done=%0d exp %h done=1", {obs_err, obs_dat}, obs_done_ok, exp_rsp);
    end
  endtask

  task automatic test_idle_ack_ignored;
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    wbm_dat_i = 32'hFFFF_FFFF;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL idle_ack_ignored got cyc=%b rsp_valid=%b ready=%b exp 0 0 1", wbm_cyc_o, rsp_valid, req_ready);
      end
    end
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_early_ready;
    exp_q.push_back(model_rsp(1'b0, 1'b1, 1'b0, 32'h7777_1111));
    run_txn(1'b0, 32'h0000_0400, 32'h0, 4'h1, 2, 1'b1, 1'b0, 32'h7777_1111, 0, 1'b1);
    exp_rsp = exp_q.pop_front();
    n_checks++;
    if (obs_cycles !== 3 || !obs_rsp_seen || {obs_err, obs_dat} !== exp_rsp || !obs_done_ok) begin
      n_errors++;
      $display("FAIL early_ready got cycles=%0d valid=%0d %h exp cycles=3 valid=1 %h",
               obs_cycles, obs_rsp_seen, {obs_err, obs_dat}, exp_rsp);
    end
  endtask

  task automatic test_random;
    bit            we;
    bit            ack;
    bit            err;
    int            kind;
    int            waits;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [DW-1:0] rdata;
    logic [SW-1:0] sel;
    for (int t = 0; t < 40; t++) begin
      we    = 1'($urandom_range(0, 1));
      adr   = $urandom;
      dat   = $urandom;
      rdata = $urandom;
      sel   = SW'($urandom_range(0, (1 << SW) - 1));
      waits = $urandom_range(0, 4);
      kind  = $urandom_range(0, 9);
      ack   = (kind != 7);
      err   = (kind >= 7);
      exp_q.push_back(model_rsp(we, ack, err, rdata));
      run_txn(we, adr, dat, sel, waits, ack, err, rdata, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      exp_rsp = exp_q.pop_front();
      n_checks++;
      if (obs_cycles !== waits + 1 || !obs_hold_ok || !obs_bp_ok || !obs_done_ok) begin
        n_errors++;
        $display("FAIL random_bus[%0d] got cycles=%0d hold=%0d bp=%0d done=%0d exp cycles=%0d all 1",
                 t, obs_cycles, obs_hold_ok, obs_bp_ok, obs_done_ok, waits + 1);
      end
      n_checks++;
      if (!obs_rsp_seen || {obs_err, obs_dat} !== exp_rsp) begin
        n_errors++;
        $display("FAIL random_rsp[%0d] got %h exp %h", t, {obs_err, obs_dat}, exp_rsp);
      end
    end
  endtask

  task automatic test_timeout;
`ifdef WB_INIT_TIMEOUT_EN
    exp_q.push_back(model_rsp(1'b0, 1'b0, 1'b0, 32'h0));
    run_txn(1'b0, 32'h0000_0500, 32'h0, 4'hF, -1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    exp_rsp = exp_q.pop_front();
    n_checks++;
    if (!obs_dropped || obs_cycles !== TIMEOUT) begin
      n_errors++;
      $display("FAIL timeout_cycles got dropped=%0d cycles=%0d exp dropped=1 cycles=%0d",
               obs_dropped, obs_cycles, TIMEOUT);
    end
    n_checks++;
    if (!obs_rsp_seen || {obs_err, obs_dat} !== exp_rsp) begin
      n_errors++;
      $display("FAIL timeout_rsp got %h exp %h", {obs_err, obs_dat}, exp_rsp);
    end
`else
    run_txn(1'b0, 32'h0000_0500, 32'h0, 4'hF, -1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    n_checks++;
    if (!obs_hung || obs_cycles !== 1000 || wbm_cyc_o !== 1'b1) begin
      n_errors++;
      $display("FAIL no_timeout got hung=%0d cycles=%0d cyc=%b exp hung=1 cycles=1000 cyc=1",
               obs_hung, obs_cycles, wbm_cyc_o);
    end
`endif
  endtask

  task automatic test_reset_mid_bus;
    if (!wbm_cyc_o) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_adr   = 32'h0000_0600;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
    end
    n_checks++;
    if (wbm_stb_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_bus_pre got stb=%b exp 1", wbm_stb_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_bus_async got cyc=%b stb=%b rsp_valid=%b exp 0 0 0", wbm_cyc_o, wbm_stb_o, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_mid_bus_after got ready=%b rsp_valid=%b cyc=%b exp 1 0 0", req_ready, rsp_valid, wbm_cyc_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_err_with_ack();
    test_backpressure();
    test_idle_ack_ignored();
    test_early_ready();
    test_random();
    test_timeout();
    test_reset_mid_bus();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
